mem_access_seq: RTL and testbench

Parametrised memory access sequencer, the next generation of the memory unit front end. It accepts byte or little-endian word requests with optional zero-page addressing and runs the external RAM bus cycle by cycle: address, active-low strobes, configurable wait states, and a strobe gap between bytes. It then returns a single-cycle completion pulse. It sits between the control unit, which raises `start`, and the RAM/bus transceivers, replacing manual MAR/MBR load and word-direction sequencing.

---
 rtl/mem_seq_pkg.sv | 25 ++
 rtl/mem_access_seq_if.sv | 32 +++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/mem_access_seq.sv | 147 ++++++++++++++
 tb/tb_mem_access_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory access sequencer.
package mem_seq_pkg;

  localparam int unsigned MEM_SEQ_WAIT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAccLo,
    StGap,
    StAccHi,
    StDone
  } mem_seq_state_t;

  // Addresses are carried at 32 bits; callers truncate back to their own width.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic zp_n,
                                            input int unsigned addr_w,
                                            input int unsigned page_w);
    logic [31:0] sum;
    logic [31:0] mask;
    sum  = addr + 32'd1;
    mask = zp_n ? ((32'd1 << addr_w) - 32'd1) : ((32'd1 << page_w) - 32'd1);
    return sum & mask;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response and RAM bus signals of the memory access sequencer.
interface mem_access_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  logic                start;
  logic                write;
  logic                word;
  logic                zero_page;
  logic [ADDR_W-1:0]   address;
  logic [2*DATA_W-1:0] wdata;
  logic [2*DATA_W-1:0] rdata;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_dout;
  logic                mem_dout_en;
  logic [DATA_W-1:0]   mem_din;
  logic                mem_out;
  logic                mem_in;

  // The master side plays both the control unit and the RAM.
  modport master (
    output start, write, word, zero_page, address, wdata, mem_din,
    input  rdata, busy, done, mem_addr, mem_dout, mem_dout_en, mem_out, mem_in
  );

  modport slave (
    input  start, write, word, zero_page, address, wdata, mem_din,
    output rdata, busy, done, mem_addr, mem_dout, mem_dout_en, mem_out, mem_in
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times strobe wait states; holds at zero.
module mem_wait_timer
  import mem_seq_pkg::*;
#(
  parameter int unsigned CNT_W = MEM_SEQ_WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: runs byte/word RAM cycles with wait states and a strobe gap.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PAGE_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_seq_if.slave  bus
);

  localparam logic [MEM_SEQ_WAIT_W-1:0] WaitInit = MEM_SEQ_WAIT_W'(WAIT_STATES);
  localparam logic [ADDR_W-1:0]         PageMask = ADDR_W'((32'd1 << PAGE_W) - 32'd1);

  mem_seq_state_t      state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [2*DATA_W-1:0] mbr_q, mbr_d;
  logic                write_q, write_d;
  logic                word_q, word_d;
  logic                zp_n_q, zp_n_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
  logic                mem_dout_en_q, mem_dout_en_d;
  logic                mem_out_q, mem_out_d;
  logic                mem_in_q, mem_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_load, tmr_zero;
  logic                acc_d;

  mem_wait_timer #(
    .CNT_W(MEM_SEQ_WAIT_W)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .value(WaitInit),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mbr_d    = mbr_q;
    write_d  = write_q;
    word_d   = word_q;
    zp_n_d   = zp_n_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mar_d    = bus.zero_page ? bus.address : (bus.address & PageMask);
          mbr_d    = bus.wdata;
          write_d  = bus.write;
          word_d   = bus.word;
          zp_n_d   = bus.zero_page;
          tmr_load = 1'b1;
          state_d  = StAccLo;
        end
      end
      StAccLo: begin
        if (tmr_zero) begin
          // First capture of a read also clears the high byte for byte reads.
          if (!write_q) rdata_d = {{DATA_W{1'b0}}, bus.mem_din};
          state_d = word_q ? StGap : StDone;
        end
      end
      StGap: begin
        mar_d    = ADDR_W'(next_addr(32'(mar_q), zp_n_q, ADDR_W, PAGE_W));
        tmr_load = 1'b1;
        state_d  = StAccHi;
      end
      StAccHi: begin
        if (tmr_zero) begin
          if (!write_q) rdata_d[2*DATA_W-1:DATA_W] = bus.mem_din;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from the next state so they leave the flops aligned to it.
  always_comb begin
    acc_d         = (state_d == StAccLo) || (state_d == StAccHi);
    mem_out_d     = !(acc_d && !write_d);
    mem_in_d      = !(acc_d && write_d);
    mem_dout_en_d = acc_d && write_d;
    mem_dout_d    = '0;
    if (mem_dout_en_d) begin
      mem_dout_d = (state_d == StAccHi) ? mbr_d[2*DATA_W-1:DATA_W] : mbr_d[DATA_W-1:0];
    end
    mem_addr_d = mar_d;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      mar_q         <= '0;
      mbr_q         <= '0;
      write_q       <= 1'b0;
      word_q        <= 1'b0;
      zp_n_q        <= 1'b1;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_dout_q    <= '0;
      mem_dout_en_q <= 1'b0;
      mem_out_q     <= 1'b1;
      mem_in_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mar_q         <= mar_d;
      mbr_q         <= mbr_d;
      write_q       <= write_d;
      word_q        <= word_d;
      zp_n_q        <= zp_n_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_dout_q    <= mem_dout_d;
      mem_dout_en_q <= mem_dout_en_d;
      mem_out_q     <= mem_out_d;
      mem_in_q      <= mem_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_dout_en = mem_dout_en_q;
  assign bus.mem_out     = mem_out_q;
  assign bus.mem_in      = mem_in_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: expected bus accesses and read results are queued per request.
module tb_mem_access_seq;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_seq_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  mem_access_seq #(
    .DATA_W(8), .ADDR_W(16), .PAGE_W(8), .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          first;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  ram [0:65535];
  logic [15:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  always_comb bus.mem_din = ram[bus.mem_addr];

  // Issue one request at the current negedge (DUT idle) and follow it cycle by cycle.
  task automatic run_request(input logic wr, input logic wd, input logic zpn,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic hold, input int poke, input string tag);
    logic [15:0] a0, a1, exp;
    int          dcyc;
    acc_t        acc, cur;
    logic        lo, e_out, e_in, e_en;
    a0   = zpn ? addr : {8'h00, addr[7:0]};
    a1   = zpn ? addr + 16'd1 : {8'h00, a0[7:0] + 8'd1};
    dcyc = wd ? 2 * WS + 4 : WS + 2;
    acc.wr = wr; acc.addr = a0; acc.data = wdata[7:0]; acc.first = 1;
    exp_acc.push_back(acc);
    if (wd) begin
      acc.addr = a1; acc.data = wdata[15:8]; acc.first = WS + 3;
      exp_acc.push_back(acc);
    end
    if (!wr) last_rd = wd ? {ram[a1], ram[a0]} : {8'h00, ram[a0]};
    exp_rd.push_back(last_rd);
    cur = acc;

    bus.write = wr; bus.word = wd; bus.zero_page = zpn; bus.address = addr;
    bus.wdata = wdata; bus.start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
      bus.start = hold || (cyc == poke);
      lo = 1'b0;
      if (exp_acc.size() > 0) begin
        cur = exp_acc[0];
        lo  = (cyc >= cur.first) && (cyc <= cur.first + WS);
      end
      e_out = !(lo && !cur.wr);
      e_in  = !(lo && cur.wr);
      e_en  = lo && cur.wr;
      checks++;
      if ({bus.mem_out, bus.mem_in, bus.mem_dout_en} !== {e_out, e_in, e_en}) begin
        errors++;
        $display("FAIL %s strobes cycle %0d: out/in/en got %b expected %b", tag, cyc,
                 {bus.mem_out, bus.mem_in, bus.mem_dout_en}, {e_out, e_in, e_en});
      end
      if (lo) begin
        checks++;
        if (bus.mem_addr !== cur.addr) begin
          errors++;
          $display("FAIL %s mem_addr cycle %0d: got %h expected %h", tag, cyc, bus.mem_addr,
                   cur.addr);
        end
        if (cur.wr) begin
          checks++;
          if (bus.mem_dout !== cur.data) begin
            errors++;
            $display("FAIL %s mem_dout cycle %0d: got %h expected %h", tag, cyc, bus.mem_dout,
                     cur.data);
          end
        end
        if (cyc == cur.first + WS) void'(exp_acc.pop_front());
      end
      checks++;
      if (bus.busy !== (cyc <= dcyc)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", tag, cyc, bus.busy, cyc <= dcyc);
      end
      checks++;
      if (bus.done !== (cyc == dcyc)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b expected %b", tag, cyc, bus.done, cyc == dcyc);
      end
      if (cyc <= dcyc) @(negedge clk);
    end
    exp = exp_rd.pop_front();
    checks++;
    if (bus.rdata !== exp) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", tag, bus.rdata, exp);
    end
    checks++;
    if (exp_acc.size() != 0) begin
      errors++;
      $display("FAIL %s accesses: got %0d missing expected 0", tag, exp_acc.size());
      exp_acc.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.mem_out, bus.mem_in, bus.mem_dout_en} !== 5'b00110) begin
      errors++;
      $display("FAIL reset flags: busy/done/out/in/en got %b expected 00110",
               {bus.busy, bus.done, bus.mem_out, bus.mem_in, bus.mem_dout_en});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_dout, bus.rdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset data: addr/dout/rdata got %h expected 0",
               {bus.mem_addr, bus.mem_dout, bus.rdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_page();
    run_request(1'b0, 1'b1, 1'b0, 16'h77FF, 16'h0000, 1'b0, 0, "zp_word_read");
    run_request(1'b1, 1'b0, 1'b0, 16'hAB42, 16'h0066, 1'b0, 0, "zp_byte_write");
  endtask

  task automatic test_byte_read();
    run_request(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, 0, "byte_read");
  endtask

  task automatic test_word_write();
    run_request(1'b1, 1'b1, 1'b1, 16'h20FF, 16'hBEEF, 1'b0, 0, "word_write");
  endtask

  task automatic test_wrap();
    run_request(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 0, "wrap_read");
  endtask

  task automatic test_start_ignored();
    run_request(1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000, 1'b0, 1, "start_ignored");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.mem_out} !== 3'b001) begin
        errors++;
        $display("FAIL start_ignored idle %0d: busy/done/out got %b expected 001", i,
                 {bus.busy, bus.done, bus.mem_out});
      end
    end
  endtask

  task automatic test_back_to_back();
    run_request(1'b1, 1'b0, 1'b1, 16'h3000, 16'h005A, 1'b1, 0, "b2b_first");
    run_request(1'b0, 1'b1, 1'b1, 16'h3010, 16'h0000, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    bus.write = 1'b1; bus.word = 1'b1; bus.zero_page = 1'b1;
    bus.address = 16'h5000; bus.wdata = 16'hC3D4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_in, bus.mem_addr, bus.mem_dout} !== {1'b0, 16'h5001, 8'hC3}) begin
      errors++;
      $display("FAIL rst_mid acc_hi: in/addr/dout got %h expected %h",
               {bus.mem_in, bus.mem_addr, bus.mem_dout}, {1'b0, 16'h5001, 8'hC3});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    checks++;
    if ({bus.busy, bus.done, bus.mem_out, bus.mem_in, bus.mem_dout_en} !== 5'b00110) begin
      errors++;
      $display("FAIL rst_mid flags: busy/done/out/in/en got %b expected 00110",
               {bus.busy, bus.done, bus.mem_out, bus.mem_in, bus.mem_dout_en});
    end
    checks++;
    if (bus.rdata !== last_rd) begin
      errors++;
      $display("FAIL rst_mid rdata: got %h expected %h", bus.rdata, last_rd);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid after %0d: busy/done got %b expected 00", i, {bus.busy, bus.done});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    ram[16'h1234] = 8'hA5;
    last_rd       = '0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.write     = 1'b0;
    bus.word      = 1'b0;
    bus.zero_page = 1'b1;
    bus.address   = '0;
    bus.wdata     = '0;
    test_reset();
    test_zero_page();
    test_byte_read();
    test_word_write();
    test_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
